// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule sequencer for one 512-bit block.
// Loads W[0..15] from the block buffer, then streams W[0..63] to the round
// datapath, expanding W[16..63] on the fly from a 16-word sliding window.
// Optional macro SHA256_SCHED_IDX_EN adds the w_idx and sticky err_ovr outputs.
module sha256_msg_sched #(
  parameter int unsigned WORD_W = 32, // only 32 is supported
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WORD_W-1:0] w_out,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              busy,
  output logic              done
`ifdef SHA256_SCHED_IDX_EN
  ,
  output logic [5:0]        w_idx,
  output logic              err_ovr
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [5:0] LastT = 6'(ROUNDS - 1);

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[WORD_W-1:7]} ^ {x[17:0], x[WORD_W-1:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[WORD_W-1:17]} ^ {x[18:0], x[WORD_W-1:19]} ^ (x >> 10);
  endfunction

  state_e            state_q, state_d;
  logic [WORD_W-1:0] window_q [16];
  logic [WORD_W-1:0] window_d [16];
  logic [3:0]        load_cnt_q, load_cnt_d;
  logic [5:0]        t_q, t_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] w_new;

  // Next schedule word W[t+16]; window[0] holds W[t], window[15] holds W[t+15].
  always_comb begin
    w_new = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];
  end

  // Next-state logic: abort overrides every other event in the same cycle.
  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d    = StIdle;
      load_cnt_d = '0;
      t_d        = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StLoad;
            load_cnt_d = '0;
          end
        end
        StLoad: begin
          if (din_valid) begin
            window_d[load_cnt_q] = din;
            load_cnt_d           = load_cnt_q + 4'd1; // wraps to 0 on the 16th word
            if (load_cnt_q == 4'd15) begin
              state_d = StRun;
              t_d     = '0;
            end
          end
        end
        StRun: begin
          if (w_ready) begin
            for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
            window_d[15] = w_new;
            if (t_q == LastT) begin
              state_d = StIdle;
              t_d     = '0;
              done_d  = 1'b1;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, window and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      window_q   <= '{default: '0};
      load_cnt_q <= '0;
      t_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      done_q     <= done_d;
    end
  end

  // Outputs decode directly from registered state, no extra latency.
  always_comb begin
    din_ready = (state_q == StLoad);
    w_valid   = (state_q == StRun);
    w_out     = (state_q == StRun) ? window_q[0] : '0;
    busy      = (state_q != StIdle);
    done      = done_q;
  end

`ifdef SHA256_SCHED_IDX_EN
  logic err_ovr_q, err_ovr_d;

  // Sticky flag: the loader offered data while the schedule was streaming.
  always_comb begin
    err_ovr_d = err_ovr_q | ((state_q == StRun) & din_valid);
  end

  // Overrun flag register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovr_q <= 1'b0;
    end else begin
      err_ovr_q <= err_ovr_d;
    end
  end

  // Round index follows t while streaming, 0 otherwise.
  always_comb begin
    w_idx   = (state_q == StRun) ? t_q : 6'd0;
    err_ovr = err_ovr_q;
  end
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: randomized self-checking bench for sha256_msg_sched.
// Expected schedules come from a direct array evaluation of the SHA-256
// recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] w_out;
  logic        w_valid;
  logic        w_ready;
  logic        busy;
  logic        done;
`ifdef SHA256_SCHED_IDX_EN
  logic [5:0]  w_idx;
  logic        err_ovr;
`endif

  always #5 clk = ~clk;

  sha256_msg_sched #(
    .WORD_W(32),
    .ROUNDS(64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .w_out    (w_out),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .busy     (busy),
    .done     (done)
`ifdef SHA256_SCHED_IDX_EN
    ,
    .w_idx    (w_idx),
    .err_ovr  (err_ovr)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] msg [16];
  logic [31:0] exp_w [64];
  logic [31:0] abc_ref [4];
  logic [31:0] got [$];
  int          timed_out;
  int          stable_err;
  int          ld_err;
  int          busy_seen;
  int          run_cycles;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a block and offer the 16 words of msg; optional random idle gaps.
  task automatic load_block(input bit gaps, input bit hold_start);
    int i;
    int guard;
    i     = 0;
    guard = 0;
    start = 1'b1;
    if (busy === 1'b1) busy_seen++;
    tick();
    start = hold_start;
    while (i < 16 && guard < 200) begin
      guard++;
      if (busy === 1'b1) busy_seen++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        din_valid = 1'b0;
        din       = $urandom;
      end else begin
        din       = msg[i];
        din_valid = 1'b1;
        if (din_ready !== 1'b1) ld_err++;
        i++;
      end
      tick();
    end
    din_valid = 1'b0;
  endtask

  // Consume the stream until done; mode 0 ready=1, 1 toggle+stall, 2 random,
  // 3 ready=1 with start held high for most of the run.
  task automatic collect(input int mode);
    int          k;
    int          stall_left;
    bit          rdy;
    bit          prev_stall;
    bit          seen;
    logic [31:0] prev_w;
    got.delete();
    timed_out  = 0;
    stable_err = 0;
    run_cycles = 0;
    k          = 0;
    stall_left = 5;
    prev_stall = 1'b0;
    prev_w     = '0;
    seen       = 1'b0;
    while (!seen && k < 400) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        rdy = 1'b1;
        case (mode)
          1: begin
            rdy = (k % 2 == 0);
            if (got.size() == 20 && stall_left > 0) begin
              rdy = 1'b0;
              stall_left--;
            end
          end
          2: rdy = 1'($urandom_range(0, 1));
          3: start = (got.size() < 60);
          default: rdy = 1'b1;
        endcase
        w_ready = rdy;
        if (prev_stall && (w_valid !== 1'b1 || w_out !== prev_w)) stable_err++;
        if (busy === 1'b1) busy_seen++;
        if (w_valid === 1'b1) run_cycles++;
        prev_stall = (w_valid === 1'b1) && !rdy;
        prev_w     = w_out;
        if (w_valid === 1'b1 && rdy) got.push_back(w_out);
        k++;
        tick();
      end
    end
    if (!seen) timed_out = 1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    w_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({din_ready, w_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {din_ready, w_valid, busy, done});
    end
    checks++;
    if (w_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_w_out got %h want 00000000", w_out);
    end
`ifdef SHA256_SCHED_IDX_EN
    checks++;
    if ({w_idx, err_ovr} !== 7'h0) begin
      errors++;
      $display("FAIL reset_idx got %h want 00", {w_idx, err_ovr});
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_abc();
    set_abc();
    build_model();
    ld_err = 0;
    load_block(1'b0, 1'b0);
    collect(0);
    checks++;
    if (timed_out != 0 || got.size() != 64) begin
      errors++;
      $display("FAIL abc_count got %0d words timeout %0d want 64", got.size(), timed_out);
    end
    checks++;
    if (run_cycles != 64 || ld_err != 0) begin
      errors++;
      $display("FAIL abc_timing got run %0d lderr %0d want 64 0", run_cycles, ld_err);
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL abc_w%0d got %h want %h", i, got[i], exp_w[i]);
      end
    end
    for (int j = 0; j < 4 && got.size() > 16 + j; j++) begin
      checks++;
      if (got[16+j] !== abc_ref[j]) begin
        errors++;
        $display("FAIL abc_known_w%0d got %h want %h", 16 + j, got[16+j], abc_ref[j]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abc_done_pulse got done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    set_abc();
    build_model();
    load_block(1'b0, 1'b0);
    collect(1);
    checks++;
    if (timed_out != 0 || got.size() != 64) begin
      errors++;
      $display("FAIL bp_count got %0d words timeout %0d want 64", got.size(), timed_out);
    end
    checks++;
    if (stable_err != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d unstable stalls want 0", stable_err);
    end
    checks++;
    if (run_cycles < 69) begin
      errors++;
      $display("FAIL bp_stall got %0d valid cycles want >= 69", run_cycles);
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL bp_w%0d got %h want %h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_loader_gaps();
    set_rand();
    build_model();
    ld_err = 0;
    load_block(1'b1, 1'b0);
    checks++;
    if (din_ready !== 1'b0 || w_valid !== 1'b1 || w_out !== msg[0] || ld_err != 0) begin
      errors++;
      $display("FAIL gaps_handover got rdy %b val %b w %h lderr %0d want 0 1 %h 0",
               din_ready, w_valid, w_out, ld_err, msg[0]);
    end
    din_valid = 1'b1;
    din       = 32'hdeadbeef;
    collect(2);
    din_valid = 1'b0;
    checks++;
    if (timed_out != 0 || got.size() != 64 || stable_err != 0) begin
      errors++;
      $display("FAIL gaps_count got %0d words timeout %0d unstable %0d want 64 0 0",
               got.size(), timed_out, stable_err);
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL gaps_w%0d got %h want %h", i, got[i], exp_w[i]);
      end
    end
`ifdef SHA256_SCHED_IDX_EN
    checks++;
    if (err_ovr !== 1'b1) begin
      errors++;
      $display("FAIL gaps_err_ovr got %b want 1", err_ovr);
    end
`endif
  endtask

  task automatic test_abort();
    set_abc();
    build_model();
    load_block(1'b0, 1'b0);
    w_ready = 1'b1;
    repeat (30) tick();
    checks++;
    if (w_valid !== 1'b1 || w_out !== exp_w[30]) begin
      errors++;
      $display("FAIL abort_t30 got val %b w %h want 1 %h", w_valid, w_out, exp_w[30]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({w_valid, din_ready, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle got %b want 0000", {w_valid, din_ready, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done got done %b busy %b want 0 0", done, busy);
      end
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_start got busy %b rdy %b want 0 0", busy, din_ready);
    end
    load_block(1'b0, 1'b0);
    collect(0);
    checks++;
    if (timed_out != 0 || got.size() != 64) begin
      errors++;
      $display("FAIL abort_reload_count got %0d words want 64", got.size());
    end
    for (int j = 0; j < 4 && got.size() > 16 + j; j++) begin
      checks++;
      if (got[16+j] !== abc_ref[j]) begin
        errors++;
        $display("FAIL abort_reload_w%0d got %h want %h", 16 + j, got[16+j], abc_ref[j]);
      end
    end
  endtask

  task automatic test_async_reset();
    set_rand();
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din       = msg[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({din_ready, w_valid, busy, done} !== 4'b0000 || w_out !== 32'h0) begin
      errors++;
      $display("FAIL arst_outputs got %b w %h want 0000 0",
               {din_ready, w_valid, busy, done}, w_out);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_no_resume got busy %b want 0", busy);
    end
    w_ready = 1'b1;
    load_block(1'b0, 1'b1);
    collect(3);
    checks++;
    if (timed_out != 0 || got.size() != 64 || run_cycles != 64) begin
      errors++;
      $display("FAIL start_ignored_count got %0d words %0d cycles want 64 64",
               got.size(), run_cycles);
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL start_ignored_w%0d got %h want %h", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_rand();
    build_model();
    busy_seen = 0;
    ld_err    = 0;
    load_block(1'b0, 1'b0);
    collect(0);
    checks++;
    if (timed_out != 0 || got.size() != 64) begin
      errors++;
      $display("FAIL b2b_a_count got %0d words want 64", got.size());
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_a_w%0d got %h want %h", i, got[i], exp_w[i]);
      end
    end
    set_abc();
    build_model();
    load_block(1'b0, 1'b0);
    collect(0);
    checks++;
    if (timed_out != 0 || got.size() != 64 || ld_err != 0) begin
      errors++;
      $display("FAIL b2b_b_count got %0d words lderr %0d want 64 0", got.size(), ld_err);
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_b_w%0d got %h want %h", i, got[i], exp_w[i]);
      end
    end
    checks++;
    if (busy_seen != 160) begin
      errors++;
      $display("FAIL b2b_cycles got %0d busy cycles want 160", busy_seen);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse got %b want 0", done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    abc_ref[0] = 32'h61626380;
    abc_ref[1] = 32'h000F0000;
    abc_ref[2] = 32'h7DA86405;
    abc_ref[3] = 32'h600003C6;
    test_reset();
    test_abc();
    test_backpressure();
    test_loader_gaps();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
